// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_adder_fulladder.sv
// Single-bit full adder used as the serial adder's bit slice.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ Cin;
  assign Carry = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands stream LSB-first through one FullAdder,
// the ripple carry lives in a flop, and the parallel result is published with a done pulse.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_next;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [WIDTH-1:0] r_next;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             slice_sum, slice_carry;
  logic             last_bit;

  FullAdder u_slice (
    .A     (a_sr[0]),
    .B     (b_sr[0]),
    .Cin   (carry_q),
    .Sum   (slice_sum),
    .Carry (slice_carry)
  );

  // Result register with the current slice bit already shifted in; on the last
  // bit this is the completed sum, so it is published without an extra cycle.
  assign r_next   = {slice_sum, r_sr[WIDTH-1:1]};
  assign last_bit = (state == SHIFT) && (cnt == LAST);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready = (state == IDLE);
  assign busy  = ~ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_sr    <= '0;
      carry_q <= 1'b0;
      cnt     <= '0;
      sum_out <= '0;
      cout    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          a_sr    <= a_in;
          b_sr    <= b_in;
          carry_q <= cin;
          cnt     <= '0;
        end
      end else begin
        a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
        b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
        r_sr    <= r_next;
        carry_q <= slice_carry;
        cnt     <= cnt + CW'(1);
        if (last_bit) begin
          sum_out <= r_next;
          cout    <= slice_carry;
          done    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed scenarios plus random operands
// checked against an arithmetic reference model.
module tb_serial_adder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a_in, b_in;
  logic         ready, busy, cout, done;
  logic [W-1:0] sum_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin     (cin),
    .ready   (ready),
    .busy    (busy),
    .sum_out (sum_out),
    .cout    (cout),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int unsigned n = 0;
    while (ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("ready_timeout", 32'(ready), 32'd1);
  endtask

  // Output registers must hold the last completed result while an operation runs.
  task automatic chk_hold(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_sum"},  32'(sum_out), 32'(exp_sum));
    chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  // One operation; if inj > 0, a start with other operands is pulsed at that busy cycle.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input int unsigned inj);
    logic [W:0] full;
    wait_ready();
    a_in = a; b_in = b; cin = c; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = $urandom; b_in = $urandom; cin = $urandom;
    full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    for (int unsigned i = 1; i <= W; i++) begin
      if (inj != 0 && i == inj) begin
        a_in = 8'h7F; b_in = 8'h7F; cin = 1'b0; start = 1'b1;
      end
      if (i > 1 || inj != 0) chk_hold("inflight");
      tick();
      start = 1'b0;
    end
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    chk("done_pulse", 32'(done), 32'd1);
    chk("ready_at_done", 32'(ready), 32'd1);
    chk("sum", 32'(sum_out), 32'(exp_sum));
    chk("cout", 32'(cout), 32'(exp_cout));
    tick();
    chk("done_clear", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("sum_hold", 32'(sum_out), 32'(exp_sum));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_busy",  32'(busy),  32'd0);
    chk("rst_done",  32'(done),  32'd0);
    chk("rst_sum",   32'(sum_out), 32'd0);
    chk("rst_cout",  32'(cout),  32'd0);

    run_op(8'h5A, 8'h33, 1'b0, 0);
    chk("basic_sum", 32'(sum_out), 32'h8D);
    run_op(8'hFF, 8'h01, 1'b0, 0);
    chk("chain1_cout", 32'(cout), 32'd1);
    run_op(8'hFF, 8'hFF, 1'b1, 0);
    chk("chain2_sum", 32'(sum_out), 32'hFF);

    // Start while busy must be ignored: one done, result 0x30, then idle stays idle.
    run_op(8'h10, 8'h20, 1'b0, 3);
    chk("busy_start_sum", 32'(sum_out), 32'h30);
    for (int unsigned i = 0; i < W + 2; i++) begin
      chk("no_second_op_done", 32'(done), 32'd0);
      chk("no_second_op_ready", 32'(ready), 32'd1);
      tick();
    end

    // Reset in the middle of an operation.
    wait_ready();
    a_in = 8'hAA; b_in = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int unsigned i = 1; i < 4; i++) begin
      chk_hold("pre_abort");
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_sum = '0; exp_cout = 1'b0;
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy",  32'(busy),  32'd0);
    chk("abort_done",  32'(done),  32'd0);
    chk("abort_sum",   32'(sum_out), 32'd0);
    chk("abort_cout",  32'(cout),  32'd0);
    for (int unsigned i = 0; i < W + 2; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end
    run_op(8'h01, 8'h02, 1'b0, 0);
    chk("post_abort_sum", 32'(sum_out), 32'h03);

    // Back-to-back with start held high: done pulses 9 clocks apart.
    begin
      int unsigned first_done = 0, second_done = 0, t = 0;
      wait_ready();
      a_in = 8'h12; b_in = 8'h34; cin = 1'b0; start = 1'b1;
      tick();
      a_in = 8'h80; b_in = 8'h80;
      while (t < 30 && second_done == 0) begin
        t++;
        if (t == W + 2) start = 1'b0;
        tick();
        if (done === 1'b1) begin
          if (first_done == 0) begin
            first_done = t;
            chk("b2b_sum1",  32'(sum_out), 32'h46);
            chk("b2b_cout1", 32'(cout), 32'd0);
          end else begin
            second_done = t;
            chk("b2b_sum2",  32'(sum_out), 32'h00);
            chk("b2b_cout2", 32'(cout), 32'd1);
          end
        end
      end
      chk("b2b_first_latency", 32'(first_done), 32'(W));
      chk("b2b_spacing", 32'(second_done - first_done), 32'(W + 1));
      exp_sum = 8'h00; exp_cout = 1'b1;
      tick();
    end

    for (int unsigned k = 0; k < 25; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), (k % 4 == 0) ? 1 + (k % W) : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single `FullAdder` bit slice. It serialises two parallel operands LSB-first through the slice, one bit per clock, and keeps the ripple carry in a flip-flop between bits. It presents the parallel sum and carry-out with a one-cycle completion pulse. It sits upstream of the slice, feeding A/B/Cin, and downstream of it, consuming Sum/Carry. It is the area-minimal alternative to a WIDTH-slice ripple adder.

## Interface
- Clocking: one clock `clk`. Reset `rst` is synchronous and active-high.
- `WIDTH`, default 8: operand and sum width. Legal range is WIDTH ≥ 2.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new addition. Sampled only when `ready`=1.
- `a_in`  in  WIDTH  operand A, captured on the accepting edge.
- `b_in`  in  WIDTH  operand B, captured on the accepting edge.
- `cin`  in  1  carry-in, captured on the accepting edge.
- `ready`  out  1  high in IDLE. Decoded combinationally from state.
- `busy`  out  1  high in SHIFT. Always equals ~`ready`.
- `sum_out`  out  WIDTH  registered result, equal to (A+B+cin) mod 2^WIDTH.
- `cout`  out  1  registered carry out of the MSB.
- `done`  out  1  registered one-cycle completion pulse.

## Operation
- States: IDLE and SHIFT.
- Reset values:
  - state = IDLE, so `ready`=1 and `busy`=0.
  - `done`=0, `sum_out`=0, `cout`=0.
  - Internal shift registers, carry flop and bit counter are all 0.
- In IDLE with `start`=1, on the clock edge:
  - load `a_in` and `b_in` into shift registers.
  - carry flop ← `cin`, bit counter ← 0, state → SHIFT.
- In IDLE with `start`=0, hold.
- In SHIFT, on every edge:
  - the slice computes from A_sr[0], B_sr[0] and the carry flop.
  - the slice's Sum shifts into the MSB of the result shift register, which shifts right.
  - A_sr and B_sr shift right, zero-filled.
  - carry flop ← slice Carry.
  - counter increments.
- On the SHIFT edge where counter == WIDTH-1 (the last bit), all of the following happen on that same edge:
  - `sum_out` ← completed result register.
  - `cout` ← final slice Carry.
  - `done` ← 1.
  - state → IDLE.
- `done` is cleared on the next edge unless another completion occurs.
- `start` while `busy`=1 is ignored. It has no effect on operands, counter or result.
- `sum_out` and `cout` hold their value from completion until the next completion. They never show partial sums.
- Arithmetic:
  - bit counter width is $clog2(WIDTH).
  - `cout` is the true carry of the WIDTH-bit addition, so 2^WIDTH overflow is reported only there.
- `rst` asserted in any state, including mid-SHIFT, returns every register to its reset value on that edge. No `done` pulse is produced for the aborted operation.

## Timing
- Accept edge is T0. SHIFT occupies edges T1…T_WIDTH.
- `done`, `sum_out` and `cout` update on edge T_WIDTH, i.e. WIDTH clocks after acceptance.
- `done` is high for exactly one cycle.
- `ready` returns high in the same cycle `done` is high. A `start` in that cycle is accepted, so throughput is one operation per WIDTH+1 clocks.
- No combinational path from any input to any output, except `ready`/`busy` derived from state.

## Structure
- Shared package `serial_adder_pkg`:
  - state encoding constants: IDLE=1'b0, SHIFT=1'b1.
  - default WIDTH constant.
- One sub-module, used unchanged: `FullAdder` (A, B, Cin → Sum, Carry), instantiated once as the bit slice.
- All sequencing lives in `serial_adder`: FSM, counter, three shift registers, carry flop and output registers.

## Test plan
All scenarios use WIDTH=8.
- Reset: hold `rst` for 2 cycles → `ready`=1, `busy`=0, `done`=0, `sum_out`=0x00, `cout`=0.
- Basic add: `a_in`=0x5A, `b_in`=0x33, `cin`=0, `start` for one cycle → `done` exactly 8 clocks after the accept edge, `sum_out`=0x8D, `cout`=0.
- Carry chain:
  - 0xFF + 0x01, `cin`=0 → `sum_out`=0x00, `cout`=1.
  - 0xFF + 0xFF, `cin`=1 → `sum_out`=0xFF, `cout`=1.
- Start while busy: accept 0x10+0x20, then pulse `start` with 0x7F+0x7F at cycle 3 → single `done`, `sum_out`=0x30, `cout`=0, no second operation.
- Reset mid-operation: accept 0xAA+0x55, assert `rst` at cycle 4 → reset values next cycle, no `done`. A following 0x01+0x02 gives 0x03.
- Back-to-back: hold `start` high with 0x12+0x34 then 0x80+0x80 → `done` pulses 9 clocks apart, with `sum_out` 0x46/`cout` 0, then 0x00/`cout` 1.
